mips_multicycle_controller: RTL
===============================

Name: mips_multicycle_controller

Overview:
- Multicycle control FSM that sequences a shared-memory MIPS datapath: one unified instruction/data memory and one ALU reused across cycles.
- Decodes op/funct from the latched instruction register and drives all datapath mux selects and write enables, one state per cycle.
- Sits beside the multicycle datapath in the next CPU top and replaces the single-cycle combinational controller.

Parameters:
- MAX_WAIT, 15, maximum cycles a memory state may stall on mem_ready before timeout. Used only with MEM_WAIT_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete; used only with MEM_WAIT_EN
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write enable
- irwrite  output  1  instruction register load
- regdst  output  1  register write address: 0 = rt, 1 = rd
- memtoreg  output  1  register write data: 0 = ALUOut, 1 = data register
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pcen  output  1  PC write enable = pcwrite | (branch & zero)
- alucontrol  output  3  ALU operation
- state  output  4  current state, for debug
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported op or funct
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- mem_timeout  output  1  sticky timeout flag; cleared only by reset

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 go to FETCH on the next edge.
- Reset: state becomes FETCH on the clock edge where reset is high. While reset is high, memwrite, irwrite, regwrite, pcen, illegal_op, instr_done and mem_timeout are forced 0. All other outputs show the FETCH decode.
- All outputs are a combinational decode of state, plus zero and funct where noted. Any signal not listed for a state is 0.
- FETCH: alusrcb=01, irwrite=1, pcwrite=1. Next state DECODE.
- DECODE: alusrcb=11. Next state by op:
  - lw 100011 or sw 101011 -> MEMADR
  - R-type 000000 -> RTYPEEX
  - beq 000100 -> BEQEX
  - addi 001000 -> ADDIEX
  - j 000010 -> JEX
  - any other op -> FETCH, with illegal_op=1
- MEMADR: alusrca=1, alusrcb=10. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next state MEMWB.
- MEMWB: memtoreg=1, regwrite=1, instr_done=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1, instr_done=1. Next state FETCH.
- RTYPEEX: alusrca=1, aluop=10. Next state ALUWB.
- ALUWB: regdst=1, regwrite=1, instr_done=1. Next state FETCH.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1, instr_done=1. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Next state ADDIWB.
- ADDIWB: regwrite=1, instr_done=1. Next state FETCH.
- JEX: pcsrc=10, pcwrite=1, instr_done=1. Next state FETCH.
- ALU decode:
  - aluop 00 -> alucontrol 010 (add); aluop 01 -> 110 (sub)
  - aluop 10 uses funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
- Unknown funct on R-type: illegal_op pulses in DECODE and the FSM returns to FETCH. No register write occurs.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset asserted mid-instruction aborts it. No write enable is asserted in that cycle.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - FETCH, MEMRD and MEMWR hold their state and outputs until mem_ready=1.
  - pcen and irwrite in FETCH are gated by mem_ready.
  - memwrite is held for the whole MEMWR stall.
  - A 4-bit wait counter clears on every state change.
  - If the counter reaches MAX_WAIT while still stalled, mem_timeout sets and the state is forced to FETCH.
- Undefined: mem_ready is ignored, mem_timeout is tied to 0, and no stalls occur.

Test Plan:
- Reset, then lw (op=100011): states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. instr_done pulses once. pcen=1 only in FETCH.
- R-type slt (op=000000, funct=101010): alucontrol=111 in RTYPEEX. ALUWB has regdst=1 and regwrite=1. Latency is 4 cycles.
- beq with zero=1, then with zero=0: pcen=1 with pcsrc=01 in BEQEX for the first; pcen=0 for the second. Both return to FETCH after 3 cycles.
- Illegal op=111111, and R-type funct=000111: illegal_op=1 in DECODE, next state FETCH, no regwrite or memwrite ever asserted.
- reset=1 asserted in MEMWR: memwrite=0 in that cycle, state=0 on the next edge.
- MEM_WAIT_EN with mem_ready held 0 in FETCH: state stays 0 with pcen=0 for 15 cycles. mem_timeout then goes to 1 and stays set until reset.

Source files
------------

// File: rtl/mips_multicycle_controller_if.sv
// mips_multicycle_controller_if: instruction fields, flags and control lines between the controller and the datapath
interface mips_multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal_op;
  logic       instr_done;
  logic       mem_timeout;
  modport master (
    input  op, funct, zero, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
           pcsrc, pcen, alucontrol, state, illegal_op, instr_done, mem_timeout
  );
  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
           pcsrc, pcen, alucontrol, state, illegal_op, instr_done, mem_timeout
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: multicycle MIPS control FSM; define MEM_WAIT_EN to stall memory states on mem_ready with timeout
module mips_multicycle_controller #(
  parameter int MAX_WAIT = 15
) (
  input logic clk,
  input logic reset,
  mips_multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    RTYPEEX = 4'd6, ALUWB = 4'd7, BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t state_q, cur, nxt;
  logic iord, mw, irw, rd, m2r, rw, asa, pcw, br, ill, done, funct_ok;
  logic [1:0] asb, pcs, aluop;
  assign funct_ok = bus.funct == 6'b100000 || bus.funct == 6'b100010 || bus.funct == 6'b100100 ||
                    bus.funct == 6'b100101 || bus.funct == 6'b101010;
`ifdef MEM_WAIT_EN
  logic [3:0] cnt;
  logic stall, tmo, to_q;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
`endif
  always_comb begin
    cur = reset ? FETCH : state_q;
    nxt = FETCH;
    iord = 1'b0;
    mw = 1'b0;
    irw = 1'b0;
    rd = 1'b0;
    m2r = 1'b0;
    rw = 1'b0;
    asa = 1'b0;
    asb = 2'b00;
    pcs = 2'b00;
    pcw = 1'b0;
    br = 1'b0;
    aluop = 2'b00;
    ill = 1'b0;
    done = 1'b0;
    case (cur)
      FETCH: begin asb = 2'b01; irw = 1'b1; pcw = 1'b1; nxt = DECODE; end
      DECODE: begin
        asb = 2'b11;
        nxt = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
              (bus.op == OP_R && funct_ok)         ? RTYPEEX :
              bus.op == OP_BEQ                     ? BEQEX :
              bus.op == OP_ADDI                    ? ADDIEX :
              bus.op == OP_J                       ? JEX : FETCH;
        ill = nxt == FETCH;
      end
      MEMADR: begin asa = 1'b1; asb = 2'b10; nxt = bus.op == OP_SW ? MEMWR : MEMRD; end
      MEMRD: begin iord = 1'b1; nxt = MEMWB; end
      MEMWB: begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
      MEMWR: begin iord = 1'b1; mw = 1'b1; done = 1'b1; end
      RTYPEEX: begin asa = 1'b1; aluop = 2'b10; nxt = ALUWB; end
      ALUWB: begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
      BEQEX: begin asa = 1'b1; aluop = 2'b01; pcs = 2'b01; br = 1'b1; done = 1'b1; end
      ADDIEX: begin asa = 1'b1; asb = 2'b10; nxt = ADDIWB; end
      ADDIWB: begin rw = 1'b1; done = 1'b1; end
      JEX: begin pcs = 2'b10; pcw = 1'b1; done = 1'b1; end
      default: nxt = FETCH;
    endcase
`ifdef MEM_WAIT_EN
    stall = (cur == FETCH || cur == MEMRD || cur == MEMWR) && !bus.mem_ready;
    tmo = stall && cnt == 4'(MAX_WAIT - 1);
    if (stall) begin
      nxt = tmo ? FETCH : cur;
      irw = 1'b0;
      pcw = 1'b0;
      done = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
`ifdef MEM_WAIT_EN
      cnt <= 4'd0;
      to_q <= 1'b0;
`endif
    end else begin
      state_q <= nxt;
`ifdef MEM_WAIT_EN
      cnt <= (nxt != state_q || tmo) ? 4'd0 : stall ? cnt + 4'd1 : cnt;
      if (tmo) to_q <= 1'b1;
`endif
    end
  end
  // write enables and pulses are suppressed in the reset cycle; everything else shows the FETCH decode
  assign bus.iord = iord;
  assign bus.memwrite = mw & ~reset;
  assign bus.irwrite = irw & ~reset;
  assign bus.regdst = rd;
  assign bus.memtoreg = m2r;
  assign bus.regwrite = rw & ~reset;
  assign bus.alusrca = asa;
  assign bus.alusrcb = asb;
  assign bus.pcsrc = pcs;
  assign bus.pcen = (pcw | (br & bus.zero)) & ~reset;
  assign bus.illegal_op = ill & ~reset;
  assign bus.instr_done = done & ~reset;
  assign bus.state = state_q;
  assign bus.alucontrol = aluop == 2'b01 ? 3'b110 :
                          aluop != 2'b10 ? 3'b010 :
                          bus.funct == 6'b100010 ? 3'b110 :
                          bus.funct == 6'b100100 ? 3'b000 :
                          bus.funct == 6'b100101 ? 3'b001 :
                          bus.funct == 6'b101010 ? 3'b111 : 3'b010;
`ifdef MEM_WAIT_EN
  assign bus.mem_timeout = to_q & ~reset;
`else
  assign bus.mem_timeout = 1'b0;
`endif
endmodule
